regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined core: NUM_RD comb read ports, NUM_WR write ports.

---
 rtl/core_pkg.sv | 17 +
 rtl/regfile_bypass.sv | 45 ++++
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants: register file geometry, architectural reset values
// and the register file sequencer states.
package core_pkg;

  localparam int          DATA_W     = 32;
  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] STACK_INIT = 32'h0001_FFFC;
  localparam logic [31:0] MMIO_INIT  = 32'hFFFF_F000;
  localparam int          STACK_ADDR = 2;
  localparam int          MMIO_ADDR  = 3;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } regfile_state_e;

endpackage

// File: rtl/regfile_bypass.sv
// One read port's view of the write ports: picks same-cycle write data over
// stored data, the highest-numbered matching port winning.
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NUM_WR = 1
) (
  input  logic [AW-1:0]            rd_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     reg_pending,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_pending
);

  logic              hit;
  logic [DATA_W-1:0] hit_data;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    // Ascending scan so the last matching port overrides earlier ones.
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr)) begin
        hit      = 1'b1;
        hit_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data    = reg_data;
    rd_pending = reg_pending;
    if (rd_addr == '0) begin
      rd_data    = '0;
      rd_pending = 1'b0;
    end else if (hit) begin
      rd_data    = hit_data;
      rd_pending = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, per-register
// pending bits and a one-register-per-cycle initialisation sequence.
module regfile_mp #(
  parameter int                DATA_W     = core_pkg::DATA_W,
  parameter int                DEPTH      = 1 << core_pkg::REG_ADDR_W,
  parameter int                NUM_RD     = 2,
  parameter int                NUM_WR     = 1,
  parameter logic [DATA_W-1:0] STACK_INIT = DATA_W'(core_pkg::STACK_INIT),
  parameter logic [DATA_W-1:0] MMIO_INIT  = DATA_W'(core_pkg::MMIO_INIT),
  localparam int               AW         = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_addr,
  output logic                     ready
);

  import core_pkg::*;

  regfile_state_e    state_reg, state_next;
  logic [AW-1:0]     idx_reg, idx_next;
  logic [DEPTH-1:0]  pending_reg, pending_next;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [DATA_W-1:0] init_value(input logic [AW-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a == AW'(STACK_ADDR)) v = STACK_INIT;
    else if (a == AW'(MMIO_ADDR)) v = MMIO_INIT;
    return v;
  endfunction

  assign ready = (state_reg == RF_READY);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      RF_CLEAR: begin
        idx_next = idx_reg + 1'b1;
        if (idx_reg == AW'(DEPTH - 1)) state_next = RF_READY;
      end
      RF_READY: state_next = RF_READY;
      default:  state_next = RF_CLEAR;
    endcase
  end

  // A new producer issued in the same cycle as a write keeps the register pending.
  always_comb begin
    pending_next = pending_reg;
    if (state_reg == RF_READY) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i]) pending_next[wr_addr[i*AW +: AW]] = 1'b0;
      end
      if (issue_en) pending_next[issue_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RF_CLEAR;
      idx_reg     <= '0;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
    end
  end

  // Storage has no reset of its own; the CLEAR walk initialises it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == RF_CLEAR) begin
        mem[idx_reg] <= init_value(idx_reg);
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
            mem[wr_addr[i*AW +: AW]] <= wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] byp_data;
      logic              byp_pend;

      assign addr = rd_addr[gi*AW +: AW];

      regfile_bypass #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .NUM_WR (NUM_WR)
      ) u_bypass (
        .rd_addr     (addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .reg_data    (mem[addr]),
        .reg_pending (pending_reg[addr]),
        .rd_data     (byp_data),
        .rd_pending  (byp_pend)
      );

      assign rd_data[gi*DATA_W +: DATA_W] = ready ? byp_data : '0;
      assign rd_pending[gi]               = ready & byp_pend;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed checks of regfile_mp against an array-based model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_pending;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic              ready;

  regfile_mp #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .NUM_RD (NR),
    .NUM_WR (NW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers, pending flags, cycles of init left.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_pend [DEPTH];
  int            clear_left;
  int            n_total = 0;
  int            n_bad   = 0;
  int            cyc     = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_regs[2] = 32'h0001_FFFC;
    m_regs[3] = 32'hFFFF_F000;
    clear_left = DEPTH;
  endtask

  task automatic model_clock();
    if (reset) begin
      model_reset();
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      for (int i = 0; i < NW; i++) begin
        int a;
        a = int'(wr_addr[i*AW +: AW]);
        if (wr_en[i] && a != 0) begin
          m_regs[a] = wr_data[i*DW +: DW];
          m_pend[a] = 1'b0;
        end
      end
      if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    end
  endtask

  task automatic expect_port(input int j, output logic [DW-1:0] d, output logic p);
    int a;
    a = int'(rd_addr[j*AW +: AW]);
    d = '0;
    p = 1'b0;
    if (clear_left == 0 && a != 0) begin
      d = m_regs[a];
      p = m_pend[a];
      for (int i = 0; i < NW; i++) begin
        if (wr_en[i] && int'(wr_addr[i*AW +: AW]) == a) begin
          d = wr_data[i*DW +: DW];
          p = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input int r0, input int r1,
                       input int e0, input int a0, input logic [DW-1:0] d0,
                       input int e1, input int a1, input logic [DW-1:0] d1,
                       input int ie, input int ia);
    rd_addr    = {AW'(r1), AW'(r0)};
    wr_en      = {1'(e1), 1'(e0)};
    wr_addr    = {AW'(a1), AW'(a0)};
    wr_data    = {d1, d0};
    issue_en   = 1'(ie);
    issue_addr = AW'(ia);
  endtask

  task automatic idle(input int r0, input int r1);
    drive(r0, r1, 0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  // Check the combinational outputs for the current inputs, then clock once.
  task automatic step(input string tag);
    logic [DW-1:0] ed;
    logic          ep;
    #1;
    check_eq({tag, "_ready"}, DW'(ready), DW'(clear_left == 0));
    for (int j = 0; j < NR; j++) begin
      expect_port(j, ed, ep);
      check_eq($sformatf("%s_data%0d", tag, j), rd_data[j*DW +: DW], ed);
      check_eq($sformatf("%s_pend%0d", tag, j), DW'(rd_pending[j]), DW'(ep));
    end
    $display("cyc %0d %s rst=%0b rdy=%0b ra=%h rd=%h rp=%b we=%b wa=%h ie=%0b ia=%0d",
             cyc, tag, reset, ready, rd_addr, rd_data, rd_pending, wr_en, wr_addr,
             issue_en, issue_addr);
    @(posedge clk);
    model_clock();
    cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle(2, 3);
    @(posedge clk);
    model_reset();
    #1;
    step("rst");

    // First CLEAR interrupted after 10 cycles; writes during CLEAR must vanish.
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(2, 5, 1, 5, $urandom, 1, 2, $urandom, 1, 5);
      step("clr1");
    end
    reset = 1'b1;
    idle(2, 3);
    step("rst2");
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(3, 5, 1, 5, $urandom, 1, 3, $urandom, 1, 5);
      step("clr2");
    end

    idle(2, 3);
    step("init23");
    idle(5, 0);
    step("init5");

    drive(7, 0, 1, 7, 32'hDEAD_BEEF, 0, 0, '0, 0, 0);
    step("byp");
    idle(7, 7);
    step("byp_hold");

    drive(0, 0, 1, 0, 32'h0000_1234, 1, 0, 32'h0000_1234, 1, 0);
    step("x0_wr");
    idle(0, 0);
    step("x0_rd");

    drive(9, 0, 0, 0, '0, 0, 0, '0, 1, 9);
    step("iss9");
    idle(9, 9);
    step("pend9");
    drive(9, 9, 1, 9, 32'd5, 0, 0, '0, 0, 0);
    step("wr9");
    idle(9, 0);
    step("clr9");

    drive(4, 0, 1, 4, 32'd1, 1, 4, 32'd2, 0, 0);
    step("coll");
    idle(4, 4);
    step("coll_rd");
    drive(4, 0, 1, 4, 32'd77, 0, 0, '0, 1, 4);
    step("iss_wr4");
    idle(4, 0);
    step("pend4");

    for (int k = 0; k < 400; k++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 7;
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, lim), $urandom_range(0, lim),
            $urandom_range(0, 1), $urandom_range(0, lim), $urandom,
            $urandom_range(0, 1), $urandom_range(0, lim), $urandom,
            $urandom_range(0, 1), $urandom_range(0, lim));
      step("rand");
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
